digclk_timer_param: RTL

Parametrised successor to the team's HH:MM:SS digital clock timer. Divides the system clock down to a 1 s tick, then keeps time in separate seconds, minutes and hours fields. Adds over the previous generation:
- a run enable;
- a validated synchronous time load;
- 12 h/24 h hour mode;
- single-cycle second-tick and day-wrap strobes.
Sits between the system clock domain and display/alarm logic.

---
 rtl/digclk_timer_param.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/digclk_timer_param.sv
// digclk_timer_param: HH:MM:SS time-of-day counter driven from a prescaled system clock.
// Supports 24 h or 12 h (+pm) hour modes, run enable, validated synchronous load,
// and one-cycle second-tick, day-wrap and load-error strobes. All outputs are registered.
// Optional sticky alarm: compile with DIGCLK_ALARM_EN defined; otherwise alarm is tied low
// and the alarm inputs are ignored.
module digclk_timer_param #(
  parameter int TICKS_PER_SEC = 100,
  parameter int MODE_12H      = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       load,
  input  logic [4:0] ld_hh,
  input  logic [5:0] ld_mm,
  input  logic [5:0] ld_ss,
  input  logic       ld_pm,
  output logic [4:0] hh,
  output logic [5:0] mm,
  output logic [5:0] ss,
  output logic       pm,
  output logic       sec_tick,
  output logic       day_wrap,
  output logic       load_err,
  input  logic       alarm_set,
  input  logic [4:0] al_hh,
  input  logic [5:0] al_mm,
  input  logic       al_pm,
  input  logic       alarm_clr,
  output logic       alarm
);

  localparam int            PW         = $clog2(TICKS_PER_SEC);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);
  localparam bit            IS_12H     = (MODE_12H != 0);
  localparam logic [4:0]    HH_RESET   = IS_12H ? 5'd12 : 5'd0;

  logic [PW-1:0] presc_q, presc_d;
  logic [4:0]    hh_q, hh_d;
  logic [5:0]    mm_q, mm_d;
  logic [5:0]    ss_q, ss_d;
  logic          pm_q, pm_d;
  logic          tick_q, tick_d;
  logic          wrap_q, wrap_d;
  logic          err_q, err_d;
  logic          ldValid;

  // Next-state: load takes priority over counting; a rejected load changes nothing but the error strobe.
  always_comb begin
    ldValid = (ld_ss <= 6'd59) && (ld_mm <= 6'd59) &&
              (IS_12H ? ((ld_hh >= 5'd1) && (ld_hh <= 5'd12)) : (ld_hh <= 5'd23));
    presc_d = presc_q;
    hh_d    = hh_q;
    mm_d    = mm_q;
    ss_d    = ss_q;
    pm_d    = pm_q;
    tick_d  = 1'b0;
    wrap_d  = 1'b0;
    err_d   = 1'b0;
    if (load) begin
      if (ldValid) begin
        hh_d    = ld_hh;
        mm_d    = ld_mm;
        ss_d    = ld_ss;
        pm_d    = IS_12H ? ld_pm : 1'b0;
        presc_d = '0;
      end else begin
        err_d = 1'b1;
      end
    end else if (en) begin
      if (presc_q == PRESC_LAST) begin
        presc_d = '0;
        tick_d  = 1'b1;
        if (ss_q == 6'd59) begin
          ss_d = 6'd0;
          if (mm_q == 6'd59) begin
            mm_d = 6'd0;
            if (IS_12H) begin
              if (hh_q == 5'd11) begin
                hh_d   = 5'd12;
                pm_d   = ~pm_q;
                wrap_d = pm_q;
              end else if (hh_q == 5'd12) begin
                hh_d = 5'd1;
              end else begin
                hh_d = hh_q + 5'd1;
              end
            end else begin
              if (hh_q == 5'd23) begin
                hh_d   = 5'd0;
                wrap_d = 1'b1;
              end else begin
                hh_d = hh_q + 5'd1;
              end
            end
          end else begin
            mm_d = mm_q + 6'd1;
          end
        end else begin
          ss_d = ss_q + 6'd1;
        end
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
  end

  // Time, prescaler and strobe registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      hh_q    <= HH_RESET;
      mm_q    <= 6'd0;
      ss_q    <= 6'd0;
      pm_q    <= 1'b0;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      presc_q <= presc_d;
      hh_q    <= hh_d;
      mm_q    <= mm_d;
      ss_q    <= ss_d;
      pm_q    <= pm_d;
      tick_q  <= tick_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
    end
  end

  assign hh       = hh_q;
  assign mm       = mm_q;
  assign ss       = ss_q;
  assign pm       = pm_q;
  assign sec_tick = tick_q;
  assign day_wrap = wrap_q;
  assign load_err = err_q;

`ifdef DIGCLK_ALARM_EN
  logic [4:0] alHh_q;
  logic [5:0] alMm_q;
  logic       alPm_q;
  logic       armed_q;
  logic       alarm_q;
  logic       alValid;
  logic       timeSet;
  logic       alMatch;

  // Alarm matches against the time being written this edge, so it rises with the new time value.
  always_comb begin
    alValid = (al_mm <= 6'd59) &&
              (IS_12H ? ((al_hh >= 5'd1) && (al_hh <= 5'd12)) : (al_hh <= 5'd23));
    timeSet = tick_d || (load && ldValid);
    alMatch = armed_q && timeSet && (hh_d == alHh_q) && (mm_d == alMm_q) &&
              (ss_d == 6'd0) && (!IS_12H || (pm_d == alPm_q));
  end

  // Alarm time registers and sticky flag; a new match beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      alHh_q  <= 5'd0;
      alMm_q  <= 6'd0;
      alPm_q  <= 1'b0;
      armed_q <= 1'b0;
      alarm_q <= 1'b0;
    end else begin
      if (alMatch) begin
        alarm_q <= 1'b1;
      end else if (alarm_clr) begin
        alarm_q <= 1'b0;
      end
      if (alarm_set && alValid) begin
        alHh_q  <= al_hh;
        alMm_q  <= al_mm;
        alPm_q  <= IS_12H ? al_pm : 1'b0;
        armed_q <= 1'b1;
      end
    end
  end

  assign alarm = alarm_q;
`else
  logic unusedAlarmInputs;
  assign unusedAlarmInputs = ^{alarm_set, al_hh, al_mm, al_pm, alarm_clr};
  assign alarm = 1'b0;
`endif

endmodule
